pipelined_adder: RTL and testbench

//  Parametrised, pipelined successor to the single-bit full_adder cells.
//  - Adds/subtracts two WIDTH-bit operands; carry chain split into STAGES

---
 rtl/pipelined_adder.sv | 112 +++++++++++
 tb/tb_pipelined_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: the carry chain is cut into STAGES slices with a register per slice.
// Each stage has valid/ready flow control, so the block sustains one beat per cycle under back-pressure.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);
   localparam int SLICE = WIDTH / STAGES;

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipelined_adder: STAGES must be 1..WIDTH and divide WIDTH");
   end

   logic [STAGES-1:0]             valid_q, valid_d, carry_q, carry_d;
   logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
   logic                          ovf_q, ovf_d;
   logic [STAGES-1:0]             ready;
   logic [STAGES-1:0]             src_valid, src_c;
   logic [STAGES-1:0][WIDTH-1:0]  src_a, src_b, src_res;
   logic [STAGES-1:0][SLICE:0]    slice_sum;

   // A stage may load when it is empty or its downstream neighbour is taking its beat.
   always_comb begin
      logic r;
      r = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         r        = !valid_q[k] || r;
         ready[k] = r;
      end
   end

   always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      ovf_d   = ovf_q;

      src_valid[0] = in_valid;
      src_a[0]     = a;
      src_b[0]     = b ^ {WIDTH{sub}};
      src_res[0]   = '0;
      src_c[0]     = ci ^ sub;
      for (int k = 1; k < STAGES; k++) begin
         src_valid[k] = valid_q[k-1];
         src_a[k]     = a_q[k-1];
         src_b[k]     = b_q[k-1];
         src_res[k]   = res_q[k-1];
         src_c[k]     = carry_q[k-1];
      end

      // Data regs load only for real beats, so bubbles never disturb held results.
      for (int k = 0; k < STAGES; k++) begin
         slice_sum[k] = {1'b0, src_a[k][k*SLICE +: SLICE]}
                      + {1'b0, src_b[k][k*SLICE +: SLICE]}
                      + {{SLICE{1'b0}}, src_c[k]};
         if (ready[k]) begin
            valid_d[k] = src_valid[k];
            if (src_valid[k]) begin
               a_d[k]                   = src_a[k];
               b_d[k]                   = src_b[k];
               res_d[k]                 = src_res[k];
               res_d[k][k*SLICE +: SLICE] = slice_sum[k][SLICE-1:0];
               carry_d[k]               = slice_sum[k][SLICE];
            end
         end
      end

      if (ready[STAGES-1] && src_valid[STAGES-1])
         ovf_d = (src_a[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1]) &&
                 (slice_sum[STAGES-1][SLICE-1] != src_a[STAGES-1][WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = ready[0];
   assign out_valid = valid_q[STAGES-1];
   assign sum       = res_q[STAGES-1];
   assign co        = carry_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four parameter sets run side by side, each with directed vectors,
// a mid-stream reset, random throughput and random back-pressure checked against an arithmetic model.
module tb_pipelined_adder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] a, b;
      logic        ci, sub;
      logic [63:0] sum;
      logic        co, ovf;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : cfg
      localparam int W = (g == 0) ? 32 : (g == 1) ? 8 : (g == 2) ? 8 : 64;
      localparam int S = (g == 0) ? 4  : (g == 1) ? 1 : (g == 2) ? 8 : 2;

      logic          rst = 1'b1, in_valid = 1'b0, ci = 1'b0, sub = 1'b0, out_ready = 1'b1;
      logic          in_ready, out_valid, co, ovf;
      logic [W-1:0]  a = '0, b = '0, sum;
      logic [W+1:0]  exp_q[$];
      int            cyc_q[$];
      logic          lat_chk = 1'b1, stalled_prev = 1'b0;
      logic [W+1:0]  prev_out, e;
      int            c;
      bit            fin = 1'b0;
      string         tag = "";

      pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
         .a(a), .b(b), .ci(ci), .sub(sub),
         .out_valid(out_valid), .out_ready(out_ready),
         .sum(sum), .co(co), .ovf(ovf)
      );

      // Returns {ovf, co, sum} from true integer add/subtract.
      function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic cin, input logic s);
         logic [W+1:0]        u;
         logic signed [W+1:0] r;
         logic                cout, o;
         if (!s) begin
            u    = {2'b00, x} + {2'b00, y} + (W+2)'(cin);
            cout = u[W];
            r    = $signed({{2{x[W-1]}}, x}) + $signed({{2{y[W-1]}}, y}) + $signed((W+2)'(cin));
         end else begin
            u    = {2'b00, x} - {2'b00, y} - (W+2)'(cin);
            cout = !u[W+1];
            r    = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y}) - $signed((W+2)'(cin));
         end
         o = !((r[W+1] == r[W]) && (r[W] == r[W-1]));
         return {o, cout, u[W-1:0]};
      endfunction

      function automatic logic [W-1:0] rnd();
         logic [63:0] r;
         r = {$urandom, $urandom};
         return r[W-1:0];
      endfunction

      always @(negedge clk) begin
         if (rst !== 1'b0) begin
            exp_q.delete();
            cyc_q.delete();
            stalled_prev = 1'b0;
         end else begin
            chk({tag, " in_ready"}, in_ready, !(exp_q.size() == S && !out_ready));
            if (stalled_prev)
               chk({tag, " stall_hold"}, {out_valid, ovf, co, sum}, {1'b1, prev_out});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk({tag, " spurious_out"}, out_valid, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  c = cyc_q.pop_front();
                  chk({tag, " result"}, {ovf, co, sum}, e);
                  if (lat_chk) chk({tag, " latency"}, cyc - c, S);
               end
            end
            if (in_valid && in_ready) begin
               exp_q.push_back(model(a, b, ci, sub));
               cyc_q.push_back(cyc);
            end
            stalled_prev = out_valid && !out_ready;
            prev_out     = {ovf, co, sum};
         end
      end

      initial begin
         vec_t        tbl[7];
         logic [63:0] ones, msb;
         int          n;
         tag  = $sformatf("W%0d_S%0d", W, S);
         ones = (W == 64) ? '1 : ((64'd1 << W) - 64'd1);
         msb  = 64'd1 << (W - 1);
         tbl[0] = '{ones,        64'd1, 1'b0, 1'b0, 64'd0,        1'b1, 1'b0};
         tbl[1] = '{msb - 64'd1, 64'd1, 1'b0, 1'b0, msb,          1'b0, 1'b1};
         tbl[2] = '{64'd5,       64'd7, 1'b0, 1'b1, ones - 64'd1, 1'b0, 1'b0};
         tbl[3] = '{64'd7,       64'd5, 1'b1, 1'b1, 64'd1,        1'b1, 1'b0};
         tbl[4] = '{msb,         64'd1, 1'b0, 1'b1, msb - 64'd1,  1'b1, 1'b1};
         tbl[5] = '{msb,         msb,   1'b0, 1'b0, 64'd0,        1'b1, 1'b1};
         tbl[6] = '{64'd0,       64'd0, 1'b1, 1'b0, 64'd1,        1'b0, 1'b0};

         repeat (3) @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         chk({tag, " reset out_valid"}, out_valid, 1'b0);
         chk({tag, " reset sum"}, sum, '0);
         chk({tag, " reset co/ovf"}, {co, ovf}, 2'b00);
         chk({tag, " reset in_ready"}, in_ready, 1'b1);

         foreach (tbl[i]) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            a = tbl[i].a[W-1:0]; b = tbl[i].b[W-1:0]; ci = tbl[i].ci; sub = tbl[i].sub;
            @(posedge clk); #1 in_valid = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (out_valid !== 1'b1 && n < 4*S + 8);
            chk($sformatf("%s dir%0d latency", tag, i), n, S);
            chk($sformatf("%s dir%0d sum", tag, i), sum, tbl[i].sum[W-1:0]);
            chk($sformatf("%s dir%0d co/ovf", tag, i), {co, ovf}, {tbl[i].co, tbl[i].ovf});
         end

         // Three beats in flight, then a two-cycle reset: none of them may come out.
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = W'(123 + i); b = W'(456); ci = 1'b1; sub = 1'b0;
         end
         @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         chk({tag, " midrst out_valid"}, out_valid, 1'b0);
         chk({tag, " midrst sum"}, sum, '0);
         chk({tag, " midrst co/ovf"}, {co, ovf}, 2'b00);
         chk({tag, " midrst in_ready"}, in_ready, 1'b1);
         repeat (2*S + 4) begin
            @(negedge clk);
            chk({tag, " midrst no_ghost"}, out_valid, 1'b0);
         end

         for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1;
            a = rnd(); b = rnd(); ci = 1'($urandom); sub = 1'($urandom);
         end
         @(posedge clk); #1 in_valid = 1'b0;
         n = 0;
         while (exp_q.size() != 0 && n < 4*S + 20) begin @(negedge clk); n++; end
         chk({tag, " throughput drained"}, exp_q.size(), 0);

         lat_chk = 1'b0;
         for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) >= 3);
            a = rnd(); b = rnd(); ci = 1'($urandom); sub = 1'($urandom);
         end
         @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
         n = 0;
         while (exp_q.size() != 0 && n < 4*S + 20) begin @(negedge clk); n++; end
         chk({tag, " backpressure drained"}, exp_q.size(), 0);
         @(posedge clk); #1 lat_chk = 1'b1;
         fin = 1'b1;
      end
   end

   initial begin
      int n = 0;
      while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin) && n < 60000) begin
         @(posedge clk);
         n++;
      end
      chk("all_configs_done", {cfg[0].fin, cfg[1].fin, cfg[2].fin, cfg[3].fin}, 4'b1111);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
